// File: rtl/core_pkg.sv
// Shared definitions for the 3-stage core: data width, the canonical NOP
// encoding used for pipeline bubbles, and the fetch controller state type.
// Honours RV_C_EXT_EN indirectly through the modules that import it.
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- what a squashed IF/EX slot holds
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_next_pc_sel.sv
// Next-PC priority mux and branch-target alignment check for pc_fetch_ctrl.
// Purely combinational. RV_C_EXT_EN relaxes target alignment to halfwords,
// which means a branch target can never be misaligned.
module next_pc_sel
  import core_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] if_size,
  input  logic            stall,
  input  logic            boot,
  input  logic            valid_ex,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            misalign
);

  localparam logic [XLEN-1:0] CLR_BIT0 = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic mret_take;
  logic br_req;
  logic br_bad;
  logic br_take;

  // Qualify EX-stage requests: a stalled EX instruction is re-evaluated later
  always_comb begin
    mret_take = mret && valid_ex && !stall;
    br_req    = br_taken && valid_ex && !stall;
`ifdef RV_C_EXT_EN
    br_bad    = 1'b0;
`else
    br_bad    = br_target[1];
`endif
    br_take   = br_req && !br_bad;
    redirect  = trap || mret_take || br_take;
    misalign  = br_req && br_bad && !trap && !mret_take;
  end

  // Priority select: trap, mret, branch, hold, sequential
  always_comb begin
    next_pc = pc + if_size;
    if (trap) begin
      next_pc = trap_vec & CLR_BIT0;
    end else if (mret_take) begin
      next_pc = mepc & CLR_BIT0;
    end else if (br_take) begin
      next_pc = br_target & CLR_BIT0;
    end else if (stall || boot) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and IF/EX pipeline register for the 3-stage core.
// Owns the PC, squashes the IF/EX slot on every redirect, and spends one
// BOOT cycle after reset before the first capture.
// Optional feature macro: RV_C_EXT_EN (compressed 16-bit instructions).
module pc_fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_taken_c,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_ex_o,
  output logic [XLEN-1:0] inst_ex_o,
  output logic            valid_ex_o,
  output logic [XLEN-1:0] link_ex_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_ex_q;
  logic [XLEN-1:0] inst_ex_q;
  logic            valid_ex_q;
  logic [2:0]      size_ex_q;
  logic            misalign_q;

  logic [XLEN-1:0] if_size;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            misalign;
  logic            boot;

  assign boot = (state == BOOT);

  // Size of the instruction currently being fetched
  always_comb begin
`ifdef RV_C_EXT_EN
    if_size = (inst_i[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
`else
    if_size = XLEN'(4);
`endif
  end

  next_pc_sel u_next_pc_sel (
    .pc        (pc_q),
    .if_size   (if_size),
    .stall     (stall_i),
    .boot      (boot),
    .valid_ex  (valid_ex_q),
    .trap      (trap_i),
    .trap_vec  (trap_vec_i),
    .mret      (mret_i),
    .mepc      (mepc_i),
    .br_taken  (br_taken_c),
    .br_target (br_target_i),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .misalign  (misalign)
  );

  // PC, fetch FSM and IF/EX register: bubble on redirect, hold on stall/boot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      pc_ex_q    <= '0;
      inst_ex_q  <= NOP_INST;
      valid_ex_q <= 1'b0;
      size_ex_q  <= 3'd4;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= next_pc;
      misalign_q <= misalign;
      if (redirect) begin
        state      <= KILL;
        inst_ex_q  <= NOP_INST;
        valid_ex_q <= 1'b0;
        size_ex_q  <= 3'd4;
      end else if (boot) begin
        state <= RUN;
      end else if (!stall_i) begin
        state      <= RUN;
        pc_ex_q    <= pc_q;
        inst_ex_q  <= inst_i;
        valid_ex_q <= 1'b1;
        size_ex_q  <= if_size[2:0];
      end
    end
  end

  assign pc_o       = pc_q;
  assign pc_ex_o    = pc_ex_q;
  assign inst_ex_o  = inst_ex_q;
  assign valid_ex_o = valid_ex_q;
  assign link_ex_o  = pc_ex_q + XLEN'(size_ex_q);
  assign redirect_o = redirect;
  assign misalign_o = misalign_q;

endmodule
